dcpu16_alu_seq: RTL and testbench

Instruction sequencer for the DCPU16 execution datapath. It accepts one decoded basic instruction at a time over a valid/ready handshake. It steps the 2-bit phase bus through operand fetch, execute and writeback, and pulses the ALU enable in the execute phase. It also evaluates the IFE/IFN/IFG/IFB conditions to skip the following instruction. It sits between the decoder and `dcpu16_alu`, and gates memory and register-file writeback.

---
 rtl/dcpu16_pkg.sv | 49 ++++
 rtl/dcpu16_tmo.sv | 31 +++
 rtl/dcpu16_alu_seq.sv | 171 +++++++++++++++++
 tb/tb_dcpu16_alu_seq.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcpu16_pkg.sv
// Shared definitions for the DCPU16 instruction sequencer: one-hot state
// encoding, basic opcodes, phase bus values and opcode-class masks.
package dcpu16_pkg;

    // One-hot state encoding
    localparam logic [5:0] ST_IDLE   = 6'b000001;
    localparam logic [5:0] ST_FETCHA = 6'b000010;
    localparam logic [5:0] ST_FETCHB = 6'b000100;
    localparam logic [5:0] ST_EXEC   = 6'b001000;
    localparam logic [5:0] ST_WBACK  = 6'b010000;
    localparam logic [5:0] ST_FAULT  = 6'b100000;

    typedef enum logic [5:0] {
        StIdle   = ST_IDLE,
        StFetchA = ST_FETCHA,
        StFetchB = ST_FETCHB,
        StExec   = ST_EXEC,
        StWback  = ST_WBACK,
        StFault  = ST_FAULT
    } state_e;

    // Basic opcodes
    localparam logic [3:0] OPC_SET = 4'h1;
    localparam logic [3:0] OPC_ADD = 4'h2;
    localparam logic [3:0] OPC_SUB = 4'h3;
    localparam logic [3:0] OPC_MUL = 4'h4;
    localparam logic [3:0] OPC_DIV = 4'h5;
    localparam logic [3:0] OPC_MOD = 4'h6;
    localparam logic [3:0] OPC_SHL = 4'h7;
    localparam logic [3:0] OPC_SHR = 4'h8;
    localparam logic [3:0] OPC_AND = 4'h9;
    localparam logic [3:0] OPC_BOR = 4'hA;
    localparam logic [3:0] OPC_XOR = 4'hB;
    localparam logic [3:0] OPC_IFE = 4'hC;
    localparam logic [3:0] OPC_IFN = 4'hD;
    localparam logic [3:0] OPC_IFG = 4'hE;
    localparam logic [3:0] OPC_IFB = 4'hF;

    // Phase bus values
    localparam logic [1:0] PHA_FA = 2'd0;
    localparam logic [1:0] PHA_FB = 2'd1;
    localparam logic [1:0] PHA_EX = 2'd2;
    localparam logic [1:0] PHA_WB = 2'd3;

    // Opcode-class masks, one bit per opcode value
    localparam logic [15:0] IS_IFX       = 16'hF000;  // IFE, IFN, IFG, IFB
    localparam logic [15:0] ILLEGAL_BASE = 16'h01E1;  // 0x0 and DIV/MOD/SHL/SHR

endpackage

// File: rtl/dcpu16_tmo.sv
// Memory-phase stall timer: counts wait cycles and flags the cycle on which
// the STALL_TMO-th consecutive wait would complete.
module dcpu16_tmo #(
    parameter int unsigned STALL_TMO = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int unsigned W = $clog2(STALL_TMO + 1);
    localparam logic [W-1:0] LIMIT = W'(STALL_TMO - 1);

    logic [W-1:0] cnt_q;

    // Count wait cycles, saturating at the limit; cleared whenever the phase ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (run && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign expired = run & (cnt_q == LIMIT);

endmodule

// File: rtl/dcpu16_alu_seq.sv
// DCPU16 instruction sequencer: steps FETCHA -> FETCHB -> EXEC -> WBACK,
// pulses the ALU enable and gates writeback.
// Define DCPU16_IFX_EN to compile in IFE/IFN/IFG/IFB evaluation and skip;
// without it those opcodes fault and skip is tied low.
module dcpu16_alu_seq
    import dcpu16_pkg::*;
#(
    parameter int unsigned STALL_TMO = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_vld,
    output logic        inst_rdy,
    input  logic [3:0]  inst_opc,
    input  logic        mem_ack,
    input  logic [15:0] regA,
    input  logic [15:0] regB,
    output logic        alu_ena,
    output logic [3:0]  alu_opc,
    output logic [1:0]  pha,
    output logic        wb_en,
    output logic        skip,
    output logic        fault,
    output logic        busy
);

    state_e      state_q;
    logic [3:0]  alu_opc_q;
    logic [1:0]  pha_q;
    logic        alu_ena_q;
    logic        wb_en_q;
    logic        fault_q;
    logic        skip_q;
    logic        waiting;
    logic        tmo_clr;
    logic        tmo_exp;
    logic        illegal;

    // Memory phases are the only states that can stall on mem_ack
    assign waiting = state_q inside {StFetchA, StFetchB, StWback};
    assign tmo_clr = ~waiting | mem_ack;

    dcpu16_tmo #(
        .STALL_TMO (STALL_TMO)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmo_clr),
        .run     (waiting),
        .expired (tmo_exp)
    );

`ifdef DCPU16_IFX_EN
    logic cond;

    // Branch condition on the EXEC-phase operands
    always_comb begin
        cond = 1'b0;
        case (alu_opc_q)
            OPC_IFE: cond = (regA == regB);
            OPC_IFN: cond = (regA != regB);
            OPC_IFG: cond = (regA > regB);
            OPC_IFB: cond = ((regA & regB) != 16'h0000);
            default: cond = 1'b0;
        endcase
    end

    assign illegal = ILLEGAL_BASE[inst_opc];
`else
    logic unused_regs;
    assign unused_regs = ^{regA, regB};
    assign skip_q      = 1'b0;
    assign illegal     = ILLEGAL_BASE[inst_opc] | IS_IFX[inst_opc];
`endif

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            alu_opc_q <= 4'h0;
            pha_q     <= PHA_FA;
            alu_ena_q <= 1'b0;
            wb_en_q   <= 1'b0;
            fault_q   <= 1'b0;
`ifdef DCPU16_IFX_EN
            skip_q    <= 1'b0;
`endif
        end else begin
            alu_ena_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (inst_vld) begin
                        if (skip_q) begin
                            // Swallow the instruction following a failed IFx
`ifdef DCPU16_IFX_EN
                            skip_q <= 1'b0;
`endif
                        end else if (illegal) begin
                            state_q <= StFault;
                            fault_q <= 1'b1;
                        end else begin
                            alu_opc_q <= inst_opc;
                            pha_q     <= PHA_FA;
                            state_q   <= StFetchA;
                        end
                    end
                end
                StFetchA: begin
                    if (mem_ack) begin
                        state_q <= StFetchB;
                        pha_q   <= PHA_FB;
                    end else if (tmo_exp) begin
                        state_q <= StFault;
                        fault_q <= 1'b1;
                    end
                end
                StFetchB: begin
                    if (mem_ack) begin
                        state_q   <= StExec;
                        pha_q     <= PHA_EX;
                        alu_ena_q <= ~IS_IFX[alu_opc_q];
                    end else if (tmo_exp) begin
                        state_q <= StFault;
                        fault_q <= 1'b1;
                    end
                end
                StExec: begin
`ifdef DCPU16_IFX_EN
                    if (IS_IFX[alu_opc_q]) begin
                        state_q <= StIdle;
                        skip_q  <= ~cond;
                    end else
`endif
                    begin
                        state_q <= StWback;
                        pha_q   <= PHA_WB;
                        wb_en_q <= 1'b1;
                    end
                end
                StWback: begin
                    if (mem_ack) begin
                        state_q <= StIdle;
                        wb_en_q <= 1'b0;
                    end else if (tmo_exp) begin
                        state_q <= StFault;
                        fault_q <= 1'b1;
                        wb_en_q <= 1'b0;
                    end
                end
                StFault: begin
                    fault_q <= 1'b1;
                end
                default: begin
                    state_q <= StFault;
                    fault_q <= 1'b1;
                    wb_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign inst_rdy = (state_q == StIdle);
    assign busy     = (state_q != StIdle);
    assign alu_ena  = alu_ena_q;
    assign alu_opc  = alu_opc_q;
    assign pha      = pha_q;
    assign wb_en    = wb_en_q;
    assign skip     = skip_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_dcpu16_alu_seq.sv
// Scoreboard bench for dcpu16_alu_seq: the driver predicts each instruction's
// outcome from phase wait counts and operand values; the monitor times the
// DUT's response from the accept edge and compares.
module tb_dcpu16_alu_seq;

    localparam int TMO = 16;

    localparam int K_NORMAL = 0;
    localparam int K_IFX    = 1;
    localparam int K_FAULT  = 2;
    localparam int K_SKIP   = 3;
    localparam int K_ABORT  = 4;

`ifdef DCPU16_IFX_EN
    localparam bit IFX_EN = 1'b1;
`else
    localparam bit IFX_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_vld;
    logic        inst_rdy;
    logic [3:0]  inst_opc;
    logic        mem_ack;
    logic [15:0] regA;
    logic [15:0] regB;
    logic        alu_ena;
    logic [3:0]  alu_opc;
    logic [1:0]  pha;
    logic        wb_en;
    logic        skip;
    logic        fault;
    logic        busy;

    dcpu16_alu_seq #(
        .STALL_TMO (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .inst_vld (inst_vld),
        .inst_rdy (inst_rdy),
        .inst_opc (inst_opc),
        .mem_ack  (mem_ack),
        .regA     (regA),
        .regB     (regB),
        .alu_ena  (alu_ena),
        .alu_opc  (alu_opc),
        .pha      (pha),
        .wb_en    (wb_en),
        .skip     (skip),
        .fault    (fault),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Cycle numbers count from the accept edge: cycle 1 follows it.
    typedef struct {
        int         kind;
        int         end_cyc;  // first cycle seen idle / faulted / in reset
        int         a_end;    // last cycle of FETCHA
        int         ex_cyc;   // EXEC cycle
        int         wb_n;     // cycles with wb_en high
        logic [3:0] opc;
        logic       skip;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errs = 0;
    bit   m_skip = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_reset_vals();
        chk("reset inst_rdy", {31'd0, inst_rdy}, 1);
        chk("reset busy", {31'd0, busy}, 0);
        chk("reset pha", {30'd0, pha}, 0);
        chk("reset alu_opc", {28'd0, alu_opc}, 0);
        chk("reset alu_ena", {31'd0, alu_ena}, 0);
        chk("reset wb_en", {31'd0, wb_en}, 0);
        chk("reset skip", {31'd0, skip}, 0);
        chk("reset fault", {31'd0, fault}, 0);
    endtask

    function automatic bit is_illegal(input logic [3:0] o);
        return (o == 4'h0) || (o >= 4'h5 && o <= 4'h8) || (!IFX_EN && o >= 4'hC);
    endfunction

    function automatic bit ifx_cond(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        case (o)
            4'hC:    return a == b;
            4'hD:    return a != b;
            4'hE:    return a > b;
            default: return (a & b) != 16'h0;
        endcase
    endfunction

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        check_reset_vals();
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_skip = 1'b0;
    endtask

    // Predict, issue one instruction, and drive mem_ack per the wait counts
    task automatic run_inst(input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b,
                            input int wa, input int wb, input int ww, input int rst_at);
        exp_t e;
        int   t;
        int   ack_a = -1;
        int   ack_b = -1;
        int   ack_w = -1;
        int   n;
        bit   c;
        e.kind = K_NORMAL; e.end_cyc = 0; e.a_end = 0; e.ex_cyc = 0; e.wb_n = 0;
        e.opc = opc; e.skip = 1'b0;
        if (m_skip) begin
            e.kind = K_SKIP; e.end_cyc = 1; m_skip = 1'b0;
        end else if (is_illegal(opc)) begin
            e.kind = K_FAULT; e.end_cyc = 1;
        end else begin
            t = 1;
            if (wa >= TMO) begin
                e.kind = K_FAULT; e.end_cyc = t + TMO;
            end else begin
                ack_a = t + wa; e.a_end = ack_a; t = ack_a + 1;
                if (wb >= TMO) begin
                    e.kind = K_FAULT; e.end_cyc = t + TMO;
                end else begin
                    ack_b = t + wb; t = ack_b + 1; e.ex_cyc = t;
                    if (opc >= 4'hC) begin
                        c = ifx_cond(opc, a, b);
                        e.kind = K_IFX; e.skip = !c; m_skip = !c; e.end_cyc = t + 1;
                    end else begin
                        t = t + 1;
                        if (ww >= TMO) begin
                            e.kind = K_FAULT; e.end_cyc = t + TMO;
                        end else begin
                            ack_w = t + ww; e.wb_n = ww + 1; e.end_cyc = ack_w + 1;
                        end
                    end
                end
            end
        end
        if (rst_at > 0 && rst_at < e.end_cyc && (e.kind == K_NORMAL || e.kind == K_IFX)) begin
            e.kind = K_ABORT; e.end_cyc = rst_at; m_skip = 1'b0;
        end

        inst_opc = opc; regA = a; regB = b; inst_vld = 1'b1;
        exp_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!inst_rdy && n < 50);
        if (!inst_rdy) begin
            chk("inst_rdy before accept", {31'd0, inst_rdy}, 1);
            void'(exp_q.pop_back());
            inst_vld = 1'b0;
            @(posedge clk);
            #1;
            pulse_reset();
            return;
        end
        @(posedge clk);
        #1;
        inst_vld = 1'b0;
        for (int k = 1; k < e.end_cyc; k++) begin
            mem_ack = (k == ack_a) || (k == ack_b) || (k == ack_w);
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0;
        if (e.kind == K_ABORT) begin
            pulse_reset();
        end else if (e.kind == K_FAULT) begin
            inst_vld = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            inst_vld = 1'b0;
            chk("fault sticky", {31'd0, fault}, 1);
            chk("fault inst_rdy", {31'd0, inst_rdy}, 0);
            chk("fault busy", {31'd0, busy}, 1);
            pulse_reset();
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int exp_pha(input exp_t e, input int k);
        if (k <= e.a_end) return 0;
        if (k < e.ex_cyc) return 1;
        if (k == e.ex_cyc) return 2;
        return (e.kind == K_IFX) ? 2 : 3;
    endfunction

    // Follow one accepted instruction to completion and compare
    task automatic track(input exp_t e);
        int         k = 0;
        int         kind = -1;
        int         ena_n = 0;
        int         ena_k = 0;
        int         wb_n = 0;
        int         pha_bad = 0;
        logic [3:0] opc_seen = 4'h0;
        logic       skip_end = 1'b0;
        bit         done = 1'b0;
        while (!done && k < 300) begin
            @(negedge clk);
            k++;
            if (rst) begin
                kind = K_ABORT; done = 1'b1;
            end else begin
                if (alu_ena) begin ena_n++; ena_k = k; opc_seen = alu_opc; end
                if (wb_en) wb_n++;
                if (int'(pha) != exp_pha(e, k)) pha_bad++;
                skip_end = skip;
                if (fault) begin
                    kind = K_FAULT; done = 1'b1;
                end else if (inst_rdy) begin
                    done = 1'b1;
                    if (wb_n > 0) kind = K_NORMAL;
                    else if (k == 1 && ena_n == 0) kind = K_SKIP;
                    else kind = K_IFX;
                end
            end
        end
        chk("completion within bound", {31'd0, done}, 1);
        chk("outcome kind", kind, e.kind);
        chk("completion cycle", k, e.end_cyc);
        if (e.kind == K_NORMAL) begin
            chk("alu_ena pulses", ena_n, 1);
            chk("alu_ena cycle", ena_k, e.ex_cyc);
            chk("alu_opc at exec", {28'd0, opc_seen}, {28'd0, e.opc});
            chk("wb_en cycles", wb_n, e.wb_n);
            chk("pha trace errors", pha_bad, 0);
            chk("skip after op", {31'd0, skip_end}, 0);
        end else if (e.kind == K_IFX) begin
            chk("ifx alu_ena pulses", ena_n, 0);
            chk("ifx wb_en cycles", wb_n, 0);
            chk("ifx pha trace errors", pha_bad, 0);
            chk("ifx skip", {31'd0, skip_end}, {31'd0, e.skip});
        end else if (e.kind == K_SKIP) begin
            chk("skipped alu_ena", ena_n, 0);
            chk("skipped wb_en", wb_n, 0);
            chk("skip cleared", {31'd0, skip_end}, 0);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && inst_vld && inst_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected accept", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    track(e);
                end
            end
        end
    end

    function automatic int rand_wait();
        int r = $urandom_range(0, 99);
        if (r < 2) return TMO;
        if (r < 5) return TMO - 1;
        return $urandom_range(0, 3);
    endfunction

    initial begin
        logic [3:0]  o;
        logic [15:0] a;
        logic [15:0] b;
        int          sel;
        int          ra;
        rst = 1'b1; inst_vld = 1'b0; mem_ack = 1'b0; inst_opc = 4'h0; regA = 16'h0; regB = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals();
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_inst(4'h2, 16'h0001, 16'h0002, 0, 0, 0, 0);   // ADD, back-to-back acks
        run_inst(4'hC, 16'h1234, 16'h1234, 0, 0, 0, 0);   // IFE equal
        run_inst(4'h1, 16'h0000, 16'h0005, 0, 0, 0, 0);
        run_inst(4'hC, 16'h1234, 16'h1235, 0, 0, 0, 0);   // IFE unequal
        run_inst(4'h1, 16'h0000, 16'h0005, 0, 0, 0, 0);   // consumed
        run_inst(4'h1, 16'h0000, 16'h0006, 0, 0, 0, 0);
        run_inst(4'hE, 16'h8000, 16'h7FFF, 0, 0, 0, 0);   // IFG unsigned
        run_inst(4'h1, 16'h0000, 16'h0007, 0, 0, 0, 0);
        run_inst(4'hF, 16'h00F0, 16'h0F00, 0, 0, 0, 0);   // IFB disjoint
        run_inst(4'h1, 16'h0000, 16'h0008, 0, 0, 0, 0);
        run_inst(4'h5, 16'h0000, 16'h0000, 0, 0, 0, 0);   // DIV
        run_inst(4'h3, 16'h0003, 16'h0001, 0, TMO, 0, 0); // FETCHB timeout
        run_inst(4'h3, 16'h0003, 16'h0001, 0, TMO - 1, 0, 0);
        run_inst(4'hB, 16'h00FF, 16'h0F0F, TMO - 1, 0, TMO - 1, 0);
        run_inst(4'h2, 16'h0001, 16'h0001, 0, 0, TMO, 0); // WBACK timeout
        run_inst(4'h2, 16'h0001, 16'h0001, 0, 0, 6, 5);   // reset during WBACK
        run_inst(4'h1, 16'h0000, 16'h0009, 1, 2, 3, 0);

        for (int i = 0; i < 120; i++) begin
            o = 4'($urandom_range(0, 15));
            a = 16'($urandom_range(0, 65535));
            sel = $urandom_range(0, 3);
            case (sel)
                0:       b = a;
                1:       b = ~a;
                2:       b = 16'($urandom_range(0, 65535));
                default: b = a + 16'h1;
            endcase
            ra = ($urandom_range(0, 29) == 0) ? $urandom_range(1, 6) : 0;
            run_inst(o, a, b, rand_wait(), rand_wait(), rand_wait(), ra);
        end

        repeat (2) @(posedge clk);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation did not finish (vectors=%0d)", vectors);
        $fatal(1, "watchdog expired");
    end

endmodule
